// File: rtl/cls_pkg.sv
// cls_pkg: shared types and constants for the PmodCLS command path.
package cls_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, FINISH} state_t;
    localparam int DEF_CLK_DIV  = 50;
    localparam int DEF_BYTE_GAP = 4000;
    localparam int CMD_LEN      = 6;
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/cls_command_sender_spi_byte_tx.sv
// spi_byte_tx: SPI mode-0, MSB-first 8-bit shifter with a CLK_DIV-cycle half-period counter.
module spi_byte_tx
    import cls_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       sclk,
    output logic       mosi,
    output logic       byte_done
);
    localparam int CW = clog2(CLK_DIV);
    logic [CW-1:0] cnt;
    logic [3:0]    tog;
    logic [7:0]    sh;
    logic          active;
    logic          half;
    assign half      = active && cnt == CW'(CLK_DIV - 1);
    assign byte_done = half && tog == 4'd15;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            tog    <= '0;
            sh     <= '0;
            active <= 1'b0;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
        end else if (load) begin
            cnt    <= '0;
            tog    <= '0;
            sh     <= data;
            mosi   <= data[7];
            active <= 1'b1;
            sclk   <= 1'b0;
        end else if (active) begin
            cnt <= half ? '0 : cnt + 1'b1;
            if (half) begin
                sclk   <= ~sclk;
                tog    <= tog + 4'd1;
                active <= !byte_done;
                // falling edge: next bit goes out while sclk is low
                if (sclk) begin
                    sh   <= {sh[6:0], 1'b0};
                    mosi <= sh[6];
                end
            end
        end
    end
endmodule

// File: rtl/cls_command_sender.sv
// cls_command_sender: walks the command lookup and streams each byte to the PmodCLS over SPI.
module cls_command_sender
    import cls_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int BYTE_GAP  = DEF_BYTE_GAP,
    parameter int NUM_BYTES = CMD_LEN,
    parameter int SEL_W     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [SEL_W-1:0] sel,
    input  logic [7:0]       cmd_byte,
    output logic             busy,
    output logic             done,
    output logic             ss_n,
    output logic             sclk,
    output logic             mosi
);
    localparam int GW = clog2(BYTE_GAP);
    state_t        state, nxt;
    logic [GW-1:0] gap_cnt;
    logic          byte_done;
    logic          last_byte;
    logic          gap_end;
    assign last_byte = sel == SEL_W'(NUM_BYTES - 1);
    assign gap_end   = gap_cnt == GW'(BYTE_GAP - 1);
    spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (state == LOAD),
        .data      (cmd_byte),
        .sclk      (sclk),
        .mosi      (mosi),
        .byte_done (byte_done)
    );
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? LOAD : IDLE;
            LOAD:    nxt = SHIFT;
            SHIFT:   nxt = byte_done ? (last_byte ? FINISH : GAP) : SHIFT;
            GAP:     nxt = gap_end ? LOAD : GAP;
            FINISH:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end
    // ss_n drops on acceptance so back-to-back strings are split by a single IDLE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ss_n    <= 1'b1;
            gap_cnt <= '0;
        end else begin
            done    <= state == FINISH;
            gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
            if (state == IDLE && start) begin
                sel  <= '0;
                busy <= 1'b1;
                ss_n <= 1'b0;
            end
            if (state == GAP && gap_end) sel <= sel + 1'b1;
            if (state == FINISH) begin
                ss_n <= 1'b1;
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cls_command_sender.sv
// tb_cls_command_sender: scoreboard bench with an SPI slave model and protocol monitor.
module tb_cls_command_sender;
    localparam int CD  = 2;
    localparam int BG  = 3;
    localparam int NB  = 6;
    localparam int LAT = NB * (1 + 16 * CD) + (NB - 1) * BG + 1;
    logic       clk = 0, rst_n = 1, start = 0, s_start = 0;
    logic [5:0] sel, s_sel;
    logic [7:0] cmd_byte, s_cmd;
    logic       busy, done, ss_n, sclk, mosi;
    logic       s_busy, s_done, s_ss_n, s_sclk, s_mosi;
    logic [7:0] tbl [8] = '{8'h1B, 8'h5B, 8'h6A, 8'h30, 8'h30, 8'h31, 8'h00, 8'h00};
    int         n_chk = 0, n_fail = 0, cyc = 0, rises = 0, dones = 0, bitc = 0;
    logic [7:0] byte_q [$];
    int         done_q [$];
    logic       psclk = 0, pmosi = 0, pdone = 0;
    logic [7:0] rx = 0;
    assign cmd_byte = tbl[sel[2:0]];
    assign s_cmd    = 8'hA5;
    cls_command_sender #(.CLK_DIV(CD), .BYTE_GAP(BG), .NUM_BYTES(NB), .SEL_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .cmd_byte(cmd_byte),
        .busy(busy), .done(done), .ss_n(ss_n), .sclk(sclk), .mosi(mosi)
    );
    cls_command_sender #(.CLK_DIV(1), .BYTE_GAP(1), .NUM_BYTES(1), .SEL_W(6)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .sel(s_sel), .cmd_byte(s_cmd),
        .busy(s_busy), .done(s_done), .ss_n(s_ss_n), .sclk(s_sclk), .mosi(s_mosi)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // slave model, done scoreboard and protocol monitor
    always @(negedge clk) begin
        if (!rst_n) bitc = 0;
        else begin
            if (sclk && !psclk && !ss_n) begin
                rises++;
                rx = {rx[6:0], mosi};
                bitc++;
                if (bitc == 8) begin
                    bitc = 0;
                    if (byte_q.size() == 0) chk("unexpected_byte", {24'd0, rx}, 32'hFFFF_FFFF);
                    else chk("rx_byte", {24'd0, rx}, {24'd0, byte_q.pop_front()});
                end
            end
            if (done) begin
                dones++;
                chk("done_single_cycle", pdone, 0);
                chk("busy_falls_with_done", busy, 0);
                if (done_q.size() == 0) chk("unexpected_done", 1, 0);
                else chk("done_cycle", cyc, done_q.pop_front());
            end
            if (sclk) chk("mosi_stable_high", mosi, pmosi);
            if (ss_n) chk("sclk_idle_ss_high", sclk, 0);
        end
        psclk = sclk;
        pmosi = mosi;
        pdone = done;
    end
    task automatic issue();
        @(negedge clk);
        start = 1;
        for (int i = 0; i < NB; i++) byte_q.push_back(tbl[i]);
        @(negedge clk);
        start = 0;
        done_q.push_back(cyc + LAT);
        chk("busy_after_start", busy, 1);
        chk("sel_after_start", sel, 0);
    endtask
    task automatic wait_done(input int lim);
        int k = 0;
        while (!done && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int r0, d0, c0, k, nb;
        logic [7:0] bits;
        logic ps, pm;
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ss_n", ss_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        rst_n = 1;
        repeat (2) @(negedge clk);
        // full string, 48 rising edges, sel holds its final value
        r0 = rises;
        issue();
        wait_done(400);
        chk("rises_per_txn", rises - r0, 48);
        chk("sel_at_done", sel, NB - 1);
        repeat (5) @(negedge clk);
        chk("sel_hold", sel, NB - 1);
        chk("ss_n_idle", ss_n, 1);
        // start during busy is ignored
        d0 = dones;
        r0 = rises;
        issue();
        repeat (48) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        wait_done(400);
        repeat (30) @(negedge clk);
        chk("single_done", dones - d0, 1);
        chk("rises_busy_start", rises - r0, 48);
        // start held high: back-to-back strings
        @(negedge clk);
        start = 1;
        for (int i = 0; i < 2 * NB; i++) byte_q.push_back(tbl[i % NB]);
        @(negedge clk);
        c0 = cyc;
        done_q.push_back(c0 + LAT);
        done_q.push_back(c0 + 2 * LAT + 1);
        wait_done(400);
        chk("b2b_ss_n_gap", ss_n, 1);
        @(negedge clk);
        chk("b2b_ss_n_low", ss_n, 0);
        chk("b2b_sel_zero", sel, 0);
        chk("b2b_busy", busy, 1);
        start = 0;
        wait_done(400);
        repeat (5) @(negedge clk);
        // reset during byte 2
        issue();
        k = 0;
        while (sel != 1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("reach_byte2", sel, 1);
        repeat (10) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_ss_n", ss_n, 1);
        chk("rst_mid_sclk", sclk, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_sel", sel, 0);
        byte_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        r0 = rises;
        repeat (60) @(negedge clk);
        chk("no_sclk_after_rst", rises - r0, 0);
        chk("idle_after_rst", ss_n, 1);
        issue();
        wait_done(400);
        repeat (3) @(negedge clk);
        // single byte, CLK_DIV=1
        s_start = 1;
        @(negedge clk);
        s_start = 0;
        c0 = cyc;
        bits = 0;
        nb = 0;
        ps = s_sclk;
        pm = s_mosi;
        for (int i = 0; i < 40 && !s_done; i++) begin
            @(negedge clk);
            if (s_sclk && !ps) begin
                bits = {bits[6:0], s_mosi};
                nb++;
            end
            if (s_sclk) chk("s_mosi_stable", s_mosi, pm);
            if (s_ss_n) chk("s_sclk_idle", s_sclk, 0);
            ps = s_sclk;
            pm = s_mosi;
        end
        chk("s_done_seen", s_done, 1);
        chk("s_done_cycle", cyc - c0, 18);
        chk("s_bits", bits, 8'hA5);
        chk("s_rises", nb, 8);
        chk("s_busy_done", s_busy, 0);
        @(negedge clk);
        chk("s_done_pulse", s_done, 0);
        chk("s_sel", s_sel, 0);
        chk("s_ss_n_end", s_ss_n, 1);
        chk("byte_q_drained", byte_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
